// File: rtl/cal_pkg.sv
// Purpose : shared types and constants for the calibration sweep sequencer.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Contents: FSM state enum, error codes, watchdog limit, latched run config,
//           and the config sanity check applied when a sweep is requested.
package cal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } cal_state_t;

    typedef enum logic [1:0] {
        CAL_ERR_NONE = 2'd0,
        CAL_ERR_CFG  = 2'd1,
        CAL_ERR_TMO  = 2'd2
    } cal_err_t;

    // Clocks in RUN without a rise of cal before the sweep is declared dead.
    localparam logic [7:0] CAL_WDOG_LIMIT = 8'd255;

    // Config held for the whole sweep. The start value needs no copy here:
    // it is loaded straight into cal_para when the sweep is accepted.
    typedef struct packed {
        logic [5:0] div_stop;
        logic [5:0] div_step;
        logic [7:0] dwell;
        logic [7:0] gap;
    } cal_cfg_t;

    function automatic logic cfg_ok(input logic [5:0] div_start,
                                    input logic [5:0] div_stop,
                                    input logic [5:0] div_step,
                                    input logic [7:0] dwell);
        return (div_start != 6'd0) && (div_step != 6'd0) &&
               (dwell != 8'd0) && (div_start <= div_stop);
    endfunction

endpackage

// File: rtl/cal_sweep_ctrl_if.sv
// Purpose : bundles host config/status and divider control of the sweep sequencer.
// Latency : n/a (wiring only).
// Backpr. : none; go/abort are single-cycle requests, status is level/pulse.
//
// master : host register file plus divider (drives requests, config and cal).
// slave  : cal_sweep_ctrl (drives cal_start/cal_para and all status outputs).
interface cal_sweep_ctrl_if;
    // host requests and config
    logic       sweep_go;
    logic       sweep_abort;
    logic [5:0] div_start;
    logic [5:0] div_stop;
    logic [5:0] div_step;
    logic [7:0] dwell;
    logic [7:0] gap;
    // divider feedback
    logic       cal;
    // divider control
    logic       cal_start;
    logic [5:0] cal_para;
    // host status
    logic       busy;
    logic [5:0] step_idx;
    logic       step_done;
    logic       sweep_done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output sweep_go, sweep_abort, div_start, div_stop, div_step, dwell, gap, cal,
        input  cal_start, cal_para, busy, step_idx, step_done, sweep_done, err, err_code
    );

    modport slave (
        input  sweep_go, sweep_abort, div_start, div_stop, div_step, dwell, gap, cal,
        output cal_start, cal_para, busy, step_idx, step_done, sweep_done, err, err_code
    );
endinterface

// File: rtl/cal_sweep_ctrl.sv
// Purpose : steps the calibration divider through start..stop, dwelling N cal periods per step.
// Latency : go -> busy 1 clk, go -> cal_start 2 clk; every output registered.
// Backpr. : none; go ignored while busy, abort wins over go and ends any sweep in 1 clk.
//
// Ports: clk_dds (clock), rst_n (sync active-low reset), bus (cal_sweep_ctrl_if.slave):
//        sweep_go/sweep_abort/div_*/dwell/gap/cal in; cal_start/cal_para/busy/
//        step_idx/step_done/sweep_done/err/err_code out.
module cal_sweep_ctrl
    import cal_pkg::*;
(
    input  logic           clk_dds,
    input  logic           rst_n,
    cal_sweep_ctrl_if.slave bus
);

    cal_state_t state_q, state_d;
    cal_cfg_t   cfg_q;

    logic       cal_q;
    logic [7:0] rise_cnt_q;
    logic [7:0] wdog_q;
    logic [7:0] gap_cnt_q;

    logic       cal_start_q, cal_start_d;
    logic [5:0] cal_para_q,  cal_para_d;
    logic       busy_q,      busy_d;
    logic [5:0] step_idx_q,  step_idx_d;
    logic       step_done_q, step_done_d;
    logic       sweep_done_q, sweep_done_d;
    logic       err_q,       err_d;
    cal_err_t   err_code_q,  err_code_d;

    logic       cfg_good, go_ok, go_bad, abort;
    logic       rise, dwell_hit, wdog_tmo, gap_end, last_step, advance;
    logic [6:0] next_sum;

    assign cfg_good = cfg_ok(bus.div_start, bus.div_stop, bus.div_step, bus.dwell);
    assign go_ok    = (state_q == IDLE) && bus.sweep_go && !bus.sweep_abort && cfg_good;
    assign go_bad   = (state_q == IDLE) && bus.sweep_go && !bus.sweep_abort && !cfg_good;
    assign abort    = (state_q != IDLE) && bus.sweep_abort;

    assign rise      = bus.cal && !cal_q;
    assign dwell_hit = rise && (rise_cnt_q == cfg_q.dwell - 8'd1);
    assign wdog_tmo  = !rise && (wdog_q == CAL_WDOG_LIMIT - 8'd1);
    // GAP is only entered with gap >= 1, so gap-1 never underflows there.
    assign gap_end   = (gap_cnt_q == cfg_q.gap - 8'd1);

    // One extra bit so a sum past 63 ends the sweep instead of wrapping.
    assign next_sum  = {1'b0, cal_para_q} + {1'b0, cfg_q.div_step};
    assign last_step = next_sum > {1'b0, cfg_q.div_stop};

    // State register
    always_ff @(posedge clk_dds) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go_ok) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (dwell_hit) begin
                    if (last_step)                 state_d = IDLE;
                    else if (cfg_q.gap == 8'd0)    state_d = LOAD;
                    else                           state_d = GAP;
                end else if (wdog_tmo) begin
                    state_d = IDLE;
                end
            end
            GAP:  if (gap_end) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cal_start_d  = (state_d == RUN);
        busy_d       = (state_d != IDLE);
        cal_para_d   = cal_para_q;
        step_idx_d   = step_idx_q;
        step_done_d  = 1'b0;
        sweep_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        advance      = 1'b0;
        if (!abort) begin
            unique case (state_q)
                IDLE: begin
                    if (go_ok) begin
                        cal_para_d = bus.div_start;
                        step_idx_d = 6'd0;
                        err_code_d = CAL_ERR_NONE;
                    end else if (go_bad) begin
                        err_d      = 1'b1;
                        err_code_d = CAL_ERR_CFG;
                    end
                end
                LOAD: ;
                RUN: begin
                    if (dwell_hit) begin
                        step_done_d  = 1'b1;
                        sweep_done_d = last_step;
                        // With no gap the next value must already be in place for LOAD.
                        advance      = !last_step && (cfg_q.gap == 8'd0);
                    end else if (wdog_tmo) begin
                        err_d      = 1'b1;
                        err_code_d = CAL_ERR_TMO;
                    end
                end
                GAP: advance = gap_end;
                default: ;
            endcase
        end
        if (advance) begin
            cal_para_d = next_sum[5:0];
            step_idx_d = step_idx_q + 6'd1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_dds) begin
        if (!rst_n) begin
            cfg_q        <= '0;
            cal_q        <= 1'b0;
            rise_cnt_q   <= 8'd0;
            wdog_q       <= 8'd0;
            gap_cnt_q    <= 8'd0;
            cal_start_q  <= 1'b0;
            cal_para_q   <= 6'd1;
            busy_q       <= 1'b0;
            step_idx_q   <= 6'd0;
            step_done_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= CAL_ERR_NONE;
        end else begin
            cal_q <= bus.cal;
            if (go_ok) begin
                cfg_q <= '{div_stop: bus.div_stop, div_step: bus.div_step,
                           dwell: bus.dwell, gap: bus.gap};
            end
            // Rise and watchdog counters only live in RUN; any other state
            // (LOAD in particular) leaves them cleared for the next step.
            if (state_q == RUN) begin
                if (rise) begin
                    rise_cnt_q <= rise_cnt_q + 8'd1;
                    wdog_q     <= 8'd0;
                end else begin
                    wdog_q     <= wdog_q + 8'd1;
                end
            end else begin
                rise_cnt_q <= 8'd0;
                wdog_q     <= 8'd0;
            end
            gap_cnt_q    <= (state_q == GAP) ? gap_cnt_q + 8'd1 : 8'd0;
            cal_start_q  <= cal_start_d;
            cal_para_q   <= cal_para_d;
            busy_q       <= busy_d;
            step_idx_q   <= step_idx_d;
            step_done_q  <= step_done_d;
            sweep_done_q <= sweep_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.cal_start  = cal_start_q;
    assign bus.cal_para   = cal_para_q;
    assign bus.busy       = busy_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.step_done  = step_done_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_cal_sweep_ctrl.sv
// Purpose : scoreboard bench for cal_sweep_ctrl driving a behavioural calibration divider.
// Latency : n/a.
// Backpr. : n/a.
module tb_cal_sweep_ctrl;

    logic clk_dds = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_dds = ~clk_dds;

    cal_sweep_ctrl_if bus();

    cal_sweep_ctrl dut (
        .clk_dds (clk_dds),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk_dds) cyc <= cyc + 1;

    // Divider: toggles cal every cal_para clocks while cal_start is high.
    int   dcnt     = 0;
    logic cal_div  = 1'b0;
    logic cal_kill = 1'b0;
    always @(posedge clk_dds) begin
        if (!bus.cal_start) begin
            dcnt    <= 0;
            cal_div <= 1'b0;
        end else if (dcnt >= int'(bus.cal_para) - 1) begin
            dcnt    <= 0;
            cal_div <= ~cal_div;
        end else begin
            dcnt <= dcnt + 1;
        end
    end
    assign bus.cal = cal_div & ~cal_kill;

    localparam int EV_RUN  = 0;
    localparam int EV_STEP = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int cyc;
        int para;
        int idx;
        int last;
        int code;
    } ev_t;

    ev_t exp_q[$];
    ev_t plan_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit cfg_valid(input int s, input int e, input int st, input int d);
        return (s >= 1) && (st >= 1) && (d >= 1) && (s <= e);
    endfunction

    // Reference: event list of a whole sweep from the timing rules.
    // RUN k starts S_k; its dwell-th rise lands at S_k + 2Pd - P + 1;
    // the next RUN starts gap + 1 clocks later (GAP then LOAD).
    task automatic plan_sweep(input int s, input int e, input int st,
                              input int d, input int g, input int e0);
        int  t, p, i;
        ev_t ev;
        plan_q.delete();
        if (!cfg_valid(s, e, st, d)) begin
            ev = '{EV_ERR, e0, 0, 0, 0, 1};
            plan_q.push_back(ev);
            return;
        end
        t = e0 + 1;
        p = s;
        i = 0;
        forever begin
            ev = '{EV_RUN, t, p, i, 0, 0};
            plan_q.push_back(ev);
            t  = t + 2 * p * d - p + 1;
            ev = '{EV_STEP, t, 0, 0, (p + st > e) ? 1 : 0, 0};
            plan_q.push_back(ev);
            if (p + st > e) break;
            t = t + g + 1;
            p = p + st;
            i = i + 1;
        end
    endtask

    // Monitor: every observed event pops the scoreboard.
    logic prev_cs = 1'b0;

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        case (kind)
            EV_RUN: begin
                chk("run_cal_para", int'(bus.cal_para), e.para);
                chk("run_step_idx", int'(bus.step_idx), e.idx);
                chk("run_busy", int'(bus.busy), 1);
            end
            EV_STEP: begin
                chk("step_done", int'(bus.step_done), 1);
                chk("sweep_done", int'(bus.sweep_done), e.last);
                chk("step_busy", int'(bus.busy), e.last ? 0 : 1);
                chk("step_cal_start", int'(bus.cal_start), 0);
            end
            default: begin
                chk("err_code", int'(bus.err_code), e.code);
                chk("err_busy", int'(bus.busy), 0);
                chk("err_cal_start", int'(bus.cal_start), 0);
                chk("err_no_done", int'(bus.step_done | bus.sweep_done), 0);
            end
        endcase
    endtask

    always @(negedge clk_dds) begin
        if (bus.cal_start && !prev_cs) take(EV_RUN);
        if (bus.step_done || bus.sweep_done) take(EV_STEP);
        if (bus.err) take(EV_ERR);
        prev_cs = bus.cal_start;
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk_dds);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_cfg(input int s, input int e, input int st, input int d, input int g);
        bus.div_start = 6'(s);
        bus.div_stop  = 6'(e);
        bus.div_step  = 6'(st);
        bus.dwell     = 8'(d);
        bus.gap       = 8'(g);
    endtask

    task automatic check_reset_values();
        chk("rst_cal_start", int'(bus.cal_start), 0);
        chk("rst_cal_para", int'(bus.cal_para), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_step_idx", int'(bus.step_idx), 0);
        chk("rst_step_done", int'(bus.step_done), 0);
        chk("rst_sweep_done", int'(bus.sweep_done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_err_code", int'(bus.err_code), 0);
    endtask

    // Issue a go; push the first 'keep' planned events (all if keep < 0).
    task automatic run_sweep(input int s, input int e, input int st,
                             input int d, input int g, input int keep);
        int e0;
        set_cfg(s, e, st, d, g);
        bus.sweep_go = 1'b1;
        e0 = cyc + 1;
        plan_sweep(s, e, st, d, g, e0);
        for (int k = 0; k < plan_q.size(); k++)
            if (keep < 0 || k < keep) exp_q.push_back(plan_q[k]);
        tick();
        bus.sweep_go = 1'b0;
        // Config must be latched: scramble the live inputs.
        bus.div_start = 6'($urandom);
        bus.div_stop  = 6'($urandom);
        bus.div_step  = 6'($urandom);
        bus.dwell     = 8'($urandom);
        bus.gap       = 8'($urandom);
        if (cfg_valid(s, e, st, d)) begin
            chk("go_busy", int'(bus.busy), 1);
            chk("go_err_code", int'(bus.err_code), 0);
            chk("go_cal_para", int'(bus.cal_para), s);
            chk("go_step_idx", int'(bus.step_idx), 0);
        end else begin
            chk("bad_go_busy", int'(bus.busy), 0);
        end
    endtask

    task automatic finish_sweep();
        wait_until(plan_q[plan_q.size() - 1].cyc + 3);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int  s0, t_run, t_step;
        ev_t ev;
        bus.sweep_go    = 1'b0;
        bus.sweep_abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // 2..6 step 2, dwell 2, gap 3: para 2,4,6, sweep_done with third step
        run_sweep(2, 6, 2, 2, 3, -1);
        finish_sweep();

        // start 1, dwell 1, gap 0: step_done 2 clocks after cal_start, LOAD straight after
        run_sweep(1, 3, 1, 1, 0, -1);
        finish_sweep();

        // 60 + 10 = 70 > 63: single step, no wrap
        run_sweep(60, 63, 10, 1, 2, -1);
        finish_sweep();

        // bad configs: step 0, then start > stop
        run_sweep(5, 9, 0, 1, 0, -1);
        finish_sweep();
        run_sweep(5, 4, 1, 1, 0, -1);
        finish_sweep();
        chk("cfg_err_code_held", int'(bus.err_code), 1);

        // watchdog: cal stuck low, timeout 255 clocks into RUN
        cal_kill = 1'b1;
        run_sweep(3, 3, 1, 1, 0, 1);
        t_run = plan_q[0].cyc;
        ev = '{EV_ERR, t_run + 255, 0, 0, 0, 2};
        exp_q.push_back(ev);
        wait_until(t_run + 258);
        chk("tmo_drained", exp_q.size(), 0);
        chk("tmo_err_code_held", int'(bus.err_code), 2);
        cal_kill = 1'b0;

        // abort inside GAP of step 1
        run_sweep(2, 10, 2, 1, 20, 4);
        t_step = plan_q[3].cyc;
        wait_until(t_step + 5);
        bus.sweep_abort = 1'b1;
        tick();
        bus.sweep_abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cal_start", int'(bus.cal_start), 0);
        chk("abort_step_idx", int'(bus.step_idx), 1);
        chk("abort_cal_para", int'(bus.cal_para), 4);
        repeat (40) tick();
        chk("abort_drained", exp_q.size(), 0);

        // go and abort together: abort wins, nothing starts
        set_cfg(3, 9, 3, 1, 0);
        bus.sweep_go    = 1'b1;
        bus.sweep_abort = 1'b1;
        tick();
        bus.sweep_go    = 1'b0;
        bus.sweep_abort = 1'b0;
        chk("goabort_busy", int'(bus.busy), 0);
        repeat (10) tick();
        chk("goabort_cal_start", int'(bus.cal_start), 0);
        chk("goabort_step_idx", int'(bus.step_idx), 1);

        // reset in the middle of RUN for step 1
        run_sweep(2, 10, 2, 1, 0, 3);
        wait_until(plan_q[2].cyc + 2);
        chk("pre_rst_cal_start", int'(bus.cal_start), 1);
        rst_n = 1'b0;
        tick();
        check_reset_values();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_drained", exp_q.size(), 0);

        // randomized sweeps, some with broken config
        for (int n = 0; n < 12; n++) begin
            int s, e, st, d, g;
            s  = $urandom_range(8, 1);
            st = $urandom_range(4, 1);
            e  = s + $urandom_range(8, 0);
            d  = $urandom_range(3, 1);
            g  = $urandom_range(4, 0);
            if ($urandom_range(3, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: s  = 0;
                    1: st = 0;
                    2: d  = 0;
                    default: e = s - 1;
                endcase
            end
            run_sweep(s, e, st, d, g, -1);
            finish_sweep();
        end

        s0 = n_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, s0);
        $finish;
    end

endmodule

// File: doc/cal_sweep_ctrl.md
# cal_sweep_ctrl

Sequencer that drives the calibration divider's `cal_start` / `cal_para` inputs. It steps the divide value from a start to a stop value in fixed increments and holds each value for a programmed number of full calibration periods. Between steps it idles for a programmed gap, and it supervises the returned `cal` square wave with a watchdog. It sits directly upstream of the calibration divider in the `clk_dds` domain. Its configuration comes from the host register file.

## Interface
- No parameters. All widths are fixed by the divider: 6-bit divide value, 8-bit counts.
- `clk_dds` in 1: DDS clock. Every register is clocked on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sweep_go` in 1: one-cycle start request. Ignored while `busy`=1.
- `sweep_abort` in 1: one-cycle abort request. Takes priority over `sweep_go`.
- `div_start` in 6: first divide value, must be ≥1.
- `div_stop` in 6: last allowed divide value, must be ≥ `div_start`.
- `div_step` in 6: increment between steps, must be ≥1.
- `dwell` in 8: full `cal` periods per step, must be ≥1.
- `gap` in 8: clocks with `cal_start`=0 between steps. 0 allowed.
- `cal` in 1: square wave returned by the divider.
- `cal_start` out 1: divider enable.
- `cal_para` out 6: divider half-period in clocks.
- `busy` out 1: high from the accepted go until return to IDLE.
- `step_idx` out 6: index of the current step, starting at 0.
- `step_done` out 1: one-cycle pulse at the end of each step's RUN.
- `sweep_done` out 1: one-cycle pulse at normal completion.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: 0 = none, 1 = bad config, 2 = timeout. Holds its value until the next accepted go.

## Operation
- The divider toggles `cal` every `cal_para` clocks while `cal_start`=1. A full period is therefore 2·`cal_para` clocks.
- FSM states and transitions:
  - IDLE: on `sweep_go`, check the config.
    - Invalid config (`div_start`=0, `div_step`=0, `dwell`=0, or `div_start`>`div_stop`): pulse `err`, set `err_code`=1, stay in IDLE.
    - Valid config: latch all config inputs, set `cal_para`=`div_start`, `step_idx`=0, `err_code`=0, `busy`=1, go to LOAD.
  - LOAD: one cycle with `cal_start`=0 and `cal_para` stable. Clear the rise counter and the watchdog. Go to RUN.
  - RUN: `cal_start`=1. Detect a rise as `cal`=1 while the registered copy `cal_q`=0, and count each rise.
    - When the count reaches `dwell`: drop `cal_start`, pulse `step_done`, compute next = `cal_para` + `div_step` at 7 bits.
    - If next > `div_stop`: pulse `sweep_done` in the same cycle as `step_done`, go to IDLE.
    - Else if `gap`=0: go to LOAD.
    - Else: go to GAP.
  - GAP: `cal_start`=0. Count `gap` clocks, then update `cal_para`=next and increment `step_idx`, then go to LOAD.
- The next value is computed at 7 bits, so sums above 63 end the sweep and never wrap.
- Watchdog in RUN: an 8-bit counter cleared on each rise. If it reaches 255 clocks without a rise, drop `cal_start`, pulse `err`, set `err_code`=2, go to IDLE. No `step_done` or `sweep_done` is pulsed.
- Abort: from any non-IDLE state, go to IDLE on the next edge with `cal_start`=0 and `busy`=0. No done or err pulse. `cal_para` and `step_idx` keep their values.

## Timing
- Reset values: `cal_start`=0, `cal_para`=1, `busy`=0, `step_idx`=0, `step_done`=0, `sweep_done`=0, `err`=0, `err_code`=0, `cal_q`=0, FSM in IDLE.
- All outputs are registered.
- `sweep_go` sampled at edge E0 gives `busy`=1 after E0 and `cal_start`=1 after E1, because LOAD lasts one cycle.
- With `cal_start` rising after edge S, the dwell-th rise is counted at edge S + 2P·`dwell` − P + 1, where P is `cal_para`. `cal_start` is low and `step_done`=1 after that edge.
- Each step occupies LOAD (1) + RUN + GAP (`gap`) clocks.
- Bad-config `err` pulses the cycle after `sweep_go`.
- Reset mid-sweep: all outputs return to their reset values on the next edge.

## Structure
- Shared package `cal_pkg` holds:
  - the FSM state enum (IDLE, LOAD, RUN, GAP);
  - error codes `CAL_ERR_NONE` / `CAL_ERR_CFG` / `CAL_ERR_TMO`;
  - `CAL_WDOG_LIMIT` = 255.
- Single module, no sub-module.
- The bench instantiates it together with the existing divider.

## Test plan
- start=2, stop=6, step=2, dwell=2, gap=3 → `cal_para` sequence 2, 4, 6; three `step_done` pulses; `sweep_done` together with the third; `busy` low afterwards.
- start=1, dwell=1, gap=0, `cal_start` rising after edge S → `step_done` after edge S+2. LOAD follows RUN immediately.
- start=60, stop=63, step=10 → single step at 60. The 7-bit sum 70 > 63 ends the sweep with no wrap to 6.
- `sweep_go` with `div_step`=0, then a separate go with `div_start`=5, `div_stop`=4 → `err` pulse each time, `err_code`=1, `busy` stays 0, `cal_start` never rises.
- `cal` held at 0 during RUN → `err` pulse 255 clocks after the last rise, `err_code`=2, `cal_start` drops.
- `sweep_abort` in GAP at step_idx 1, then `sweep_go` and `sweep_abort` in the same cycle, then `rst_n`=0 mid-RUN → IDLE after one edge each time, no done pulses, reset values after reset.
